// File: rtl/maze_path_tracker.sv
// maze_path_tracker: records the walker's start-to-goal paths into P slots,
// rejects duplicates, tracks the shortest stored path and offers a registered
// readback port.
//
// Optional build macro: MAZE_PATH_TRACKER_ADJ_CHECK_EN
//   defined   -> a step must be 4-neighbour adjacent to the previous step
//   undefined -> any in-grid step is accepted
//
// state       | meaning
// ST_RECORD   | accepting steps into slot[path_cnt]
// ST_COMPARE  | comparing the new path against stored slot cmp_idx
// ST_COMMIT   | storing the path (unique) or dropping it (duplicate)
// ST_FULL     | all slots used, no more steps until rst
module maze_path_tracker #(
    parameter int GRID_W = 10,
    parameter int GRID_H = 10,
    parameter int P      = 5,
    parameter int M      = 50,
    parameter int GOAL_X = GRID_W - 1,
    parameter int GOAL_Y = GRID_H - 1,
    localparam int XW    = $clog2(GRID_W),
    localparam int YW    = $clog2(GRID_H),
    localparam int CW    = $clog2(P + 1),
    localparam int LW    = $clog2(M + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_valid,
    output logic             step_ready,
    input  logic [XW-1:0]    step_x,
    input  logic [YW-1:0]    step_y,
    input  logic             abort,
    output logic [LW-1:0]    cur_len,
    output logic [CW-1:0]    path_cnt,
    output logic             best_valid,
    output logic [LW-1:0]    best_len,
    output logic [CW-1:0]    best_idx,
    output logic             done_pulse,
    output logic             dup_pulse,
    output logic             err_pulse,
    output logic             full,
    input  logic [CW-1:0]    rd_idx,
    input  logic [LW-1:0]    rd_step,
    output logic [XW+YW-1:0] rd_data
);

    // Storage is sized to the full index range so every index is in bounds.
    localparam int PD = 1 << CW;
    localparam int MD = 1 << LW;

    localparam logic [XW:0]   GW_L = (XW+1)'(GRID_W);
    localparam logic [YW:0]   GH_L = (YW+1)'(GRID_H);
    localparam logic [XW-1:0] GX_L = XW'(GOAL_X);
    localparam logic [YW-1:0] GY_L = YW'(GOAL_Y);
    localparam logic [LW-1:0] M_L  = LW'(M);
    localparam logic [CW-1:0] P_L  = CW'(P);

    typedef enum logic [1:0] {ST_RECORD, ST_COMPARE, ST_COMMIT, ST_FULL} state_t;

    state_t state_q, state_d;

    logic [XW+YW-1:0] slot_mem [PD][MD];
    logic [LW-1:0]    len_mem  [PD];

    logic [CW-1:0] cmp_idx;
    logic          dup_q;
    logic          in_grid, adj_ok, step_ok, is_goal, at_max;
    logic          accept, wr_en, goal_hit, match, cmp_last;

    assign in_grid  = ({1'b0, step_x} < GW_L) && ({1'b0, step_y} < GH_L);
    assign step_ok  = in_grid && adj_ok;
    assign is_goal  = (step_x == GX_L) && (step_y == GY_L);
    assign at_max   = (cur_len == M_L);
    assign accept   = step_ready && step_valid && !abort && step_ok;
    assign wr_en    = accept && !at_max;
    assign goal_hit = wr_en && is_goal;
    assign cmp_last = ((cmp_idx + CW'(1)) == path_cnt);

`ifdef MAZE_PATH_TRACKER_ADJ_CHECK_EN
    logic [XW-1:0] prev_x;
    logic [YW-1:0] prev_y;
    logic          x_nb, y_nb;

    // Unsigned +/-1 neighbour test, widened by one bit so the top cell cannot wrap.
    assign x_nb = ({1'b0, step_x} == {1'b0, prev_x} + (XW+1)'(1)) ||
                  ({1'b0, prev_x} == {1'b0, step_x} + (XW+1)'(1));
    assign y_nb = ({1'b0, step_y} == {1'b0, prev_y} + (YW+1)'(1)) ||
                  ({1'b0, prev_y} == {1'b0, step_y} + (YW+1)'(1));
    assign adj_ok = (cur_len == '0) ||
                    (x_nb && (step_y == prev_y)) ||
                    (y_nb && (step_x == prev_x));

    // Remember the last written cell for the adjacency check.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_x <= '0;
            prev_y <= '0;
        end else if (wr_en) begin
            prev_x <= step_x;
            prev_y <= step_y;
        end
    end
`else
    assign adj_ok = 1'b1;
`endif

    // Path match: same length and every recorded step equal.
    always_comb begin
        match = (len_mem[cmp_idx] == cur_len);
        for (int i = 0; i < MD; i++) begin
            if ((LW'(i) < cur_len) &&
                (slot_mem[cmp_idx][LW'(i)] != slot_mem[path_cnt][LW'(i)]))
                match = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RECORD;
        else     state_q <= state_d;
    end

    // Next-state decode and step handshake.
    always_comb begin
        state_d    = state_q;
        step_ready = 1'b0;
        case (state_q)
            ST_RECORD: begin
                step_ready = 1'b1;
                if (goal_hit)
                    state_d = (path_cnt == '0) ? ST_COMMIT : ST_COMPARE;
            end
            ST_COMPARE: begin
                if (match || cmp_last)
                    state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (!dup_q && ((path_cnt + CW'(1)) == P_L))
                    state_d = ST_FULL;
                else
                    state_d = ST_RECORD;
            end
            ST_FULL: state_d = ST_FULL;
            default: state_d = ST_RECORD;
        endcase
    end

    // Path step and length storage; no reset needed, guarded by path_cnt/len on read.
    always_ff @(posedge clk) begin
        if (wr_en)
            slot_mem[path_cnt][cur_len] <= {step_x, step_y};
        if ((state_q == ST_COMMIT) && !dup_q)
            len_mem[path_cnt] <= cur_len;
    end

    // Counters, best-path tracking, pulses and sticky full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_len    <= '0;
            path_cnt   <= '0;
            best_valid <= 1'b0;
            best_len   <= '0;
            best_idx   <= '0;
            done_pulse <= 1'b0;
            dup_pulse  <= 1'b0;
            err_pulse  <= 1'b0;
            full       <= 1'b0;
            cmp_idx    <= '0;
            dup_q      <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            dup_pulse  <= 1'b0;
            err_pulse  <= 1'b0;
            case (state_q)
                ST_RECORD: begin
                    cmp_idx <= '0;
                    dup_q   <= 1'b0;
                    if (abort) begin
                        cur_len <= '0;
                    end else if (step_valid) begin
                        if (!step_ok) begin
                            err_pulse <= 1'b1;
                        end else if (at_max) begin
                            cur_len   <= '0;
                            err_pulse <= 1'b1;
                        end else begin
                            cur_len <= cur_len + LW'(1);
                        end
                    end
                end
                ST_COMPARE: begin
                    if (match) dup_q <= 1'b1;
                    cmp_idx <= cmp_idx + CW'(1);
                end
                ST_COMMIT: begin
                    if (dup_q) begin
                        dup_pulse <= 1'b1;
                    end else begin
                        done_pulse <= 1'b1;
                        path_cnt   <= path_cnt + CW'(1);
                        if ((path_cnt + CW'(1)) == P_L) full <= 1'b1;
                        if (!best_valid || (cur_len < best_len)) begin
                            best_valid <= 1'b1;
                            best_len   <= cur_len;
                            best_idx   <= path_cnt;
                        end
                    end
                    cur_len <= '0;
                    dup_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Registered readback of stored steps; unused slots and steps read as zero.
    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= '0;
        else if ((rd_idx < path_cnt) && (rd_step < len_mem[rd_idx]))
            rd_data <= slot_mem[rd_idx][rd_step];
        else
            rd_data <= '0;
    end

endmodule

// File: tb/tb_maze_path_tracker.sv
// Directed bench for maze_path_tracker at default parameters (10x10, P=5, M=50).
module tb_maze_path_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       step_valid;
    logic       step_ready;
    logic [3:0] step_x;
    logic [3:0] step_y;
    logic       abort;
    logic [5:0] cur_len;
    logic [2:0] path_cnt;
    logic       best_valid;
    logic [5:0] best_len;
    logic [2:0] best_idx;
    logic       done_pulse;
    logic       dup_pulse;
    logic       err_pulse;
    logic       full;
    logic [2:0] rd_idx;
    logic [5:0] rd_step;
    logic [7:0] rd_data;

    int tests = 0;
    int fails = 0;
    int px[$];
    int py[$];

    maze_path_tracker dut (
        .clk        (clk),
        .rst        (rst),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .step_x     (step_x),
        .step_y     (step_y),
        .abort      (abort),
        .cur_len    (cur_len),
        .path_cnt   (path_cnt),
        .best_valid (best_valid),
        .best_len   (best_len),
        .best_idx   (best_idx),
        .done_pulse (done_pulse),
        .dup_pulse  (dup_pulse),
        .err_pulse  (err_pulse),
        .full       (full),
        .rd_idx     (rd_idx),
        .rd_step    (rd_step),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int x, input int y);
        @(negedge clk);
        step_x     = 4'(x);
        step_y     = 4'(y);
        step_valid = 1'b1;
        @(posedge clk);
        #1;
        step_valid = 1'b0;
    endtask

    task automatic run_path();
        foreach (px[i]) step(px[i], py[i]);
    endtask

    task automatic rd(input int idx, input int stp);
        @(negedge clk);
        rd_idx  = 3'(idx);
        rd_step = 6'(stp);
        tick();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 32'(step_ready), 1);
        chk({tag, "_cur_len"}, 32'(cur_len), 0);
        chk({tag, "_path_cnt"}, 32'(path_cnt), 0);
        chk({tag, "_best_valid"}, 32'(best_valid), 0);
        chk({tag, "_best_len"}, 32'(best_len), 0);
        chk({tag, "_best_idx"}, 32'(best_idx), 0);
        chk({tag, "_pulses"}, {29'd0, done_pulse, dup_pulse, err_pulse}, 0);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_rd_data"}, 32'(rd_data), 0);
    endtask

    initial begin
        rst = 1'b1; step_valid = 1'b0; step_x = '0; step_y = '0;
        abort = 1'b0; rd_idx = '0; rd_step = '0;
        tick(); tick();
        chk_reset("rst_hold");
        rst = 1'b0;
        tick();
        chk_reset("reset");

        // Path A: down column 0 then along row 9, 19 steps, k=0
        px.delete(); py.delete();
        for (int y = 0; y < 10; y++) begin px.push_back(0); py.push_back(y); end
        for (int x = 1; x < 10; x++) begin px.push_back(x); py.push_back(9); end
        run_path();
        chk("a_c1_done", 32'(done_pulse), 0);
        chk("a_c1_ready", 32'(step_ready), 0);
        chk("a_c1_len", 32'(cur_len), 19);
        tick();
        chk("a_c2_done", 32'(done_pulse), 1);
        chk("a_cnt", 32'(path_cnt), 1);
        chk("a_best_valid", 32'(best_valid), 1);
        chk("a_best_len", 32'(best_len), 19);
        chk("a_best_idx", 32'(best_idx), 0);
        chk("a_ready", 32'(step_ready), 1);
        chk("a_len_clr", 32'(cur_len), 0);
        tick();
        chk("a_done_one_cycle", 32'(done_pulse), 0);

        // Path A again: match at slot 0, dup_pulse in cycle 3
        run_path();
        tick();
        chk("dup_c2", 32'(dup_pulse), 0);
        tick();
        chk("dup_c3", 32'(dup_pulse), 1);
        chk("dup_no_done", 32'(done_pulse), 0);
        chk("dup_cnt", 32'(path_cnt), 1);

        // Path B: 21 steps with a back-step detour, k=1 -> done in cycle 3
        px.delete(); py.delete();
        px.push_back(0); py.push_back(0);
        px.push_back(0); py.push_back(1);
        px.push_back(0); py.push_back(0);
        for (int x = 1; x < 10; x++) begin px.push_back(x); py.push_back(0); end
        for (int y = 1; y < 10; y++) begin px.push_back(9); py.push_back(y); end
        run_path();
        chk("b_c1_ready", 32'(step_ready), 0);
        tick();
        chk("b_c2_done", 32'(done_pulse), 0);
        tick();
        chk("b_c3_done", 32'(done_pulse), 1);
        chk("b_cnt", 32'(path_cnt), 2);
        chk("b_best_len", 32'(best_len), 19);
        chk("b_best_idx", 32'(best_idx), 0);

        // Path C: row 0 then column 9, 19 steps (tie keeps slot 0), k=2
        px.delete(); py.delete();
        for (int x = 0; x < 10; x++) begin px.push_back(x); py.push_back(0); end
        for (int y = 1; y < 10; y++) begin px.push_back(9); py.push_back(y); end
        run_path();
        tick(); tick(); tick();
        chk("c_done", 32'(done_pulse), 1);
        chk("c_cnt", 32'(path_cnt), 3);
        chk("c_best_len", 32'(best_len), 19);
        chk("c_best_idx", 32'(best_idx), 0);

        // Path D: 18 steps starting at (1,0), k=3 -> done in cycle 5
        px.delete(); py.delete();
        for (int x = 1; x < 10; x++) begin px.push_back(x); py.push_back(0); end
        for (int y = 1; y < 10; y++) begin px.push_back(9); py.push_back(y); end
        run_path();
        tick(); tick(); tick(); tick();
        chk("d_done", 32'(done_pulse), 1);
        chk("d_cnt", 32'(path_cnt), 4);
        chk("d_best_len", 32'(best_len), 18);
        chk("d_best_idx", 32'(best_idx), 3);

        // Readback
        rd(3, 0);
        chk("rd_3_0", 32'(rd_data), 32'h10);
        rd(0, 18);
        chk("rd_0_18", 32'(rd_data), 32'h99);
        rd(0, 19);
        chk("rd_past_len", 32'(rd_data), 0);
        rd(4, 0);
        chk("rd_unstored", 32'(rd_data), 0);
        rd(1, 3);
        chk("rd_1_3", 32'(rd_data), 32'h10);

        // Adjacency: (5,5) after (0,0)
        step(0, 0);
        chk("adj_first_len", 32'(cur_len), 1);
        step(5, 5);
`ifdef MAZE_PATH_TRACKER_ADJ_CHECK_EN
        chk("adj_err", 32'(err_pulse), 1);
        chk("adj_len", 32'(cur_len), 1);
`else
        chk("adj_err", 32'(err_pulse), 0);
        chk("adj_len", 32'(cur_len), 2);
`endif

        // Abort wins over a simultaneous step
        @(negedge clk);
        abort = 1'b1; step_valid = 1'b1; step_x = 4'd0; step_y = 4'd1;
        tick();
        abort = 1'b0; step_valid = 1'b0;
        chk("abort_len", 32'(cur_len), 0);
        chk("abort_err", 32'(err_pulse), 0);

        // Out-of-grid steps keep the partial path
        step(0, 0);
        chk("oob_pre_len", 32'(cur_len), 1);
        step(10, 0);
        chk("oob_x_err", 32'(err_pulse), 1);
        chk("oob_x_len", 32'(cur_len), 1);
        step(0, 10);
        chk("oob_y_err", 32'(err_pulse), 1);
        tick();
        chk("oob_err_one_cycle", 32'(err_pulse), 0);

        // Overflow: 50 non-goal steps fill the path, the 51st clears it
        @(negedge clk);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_alone_len", 32'(cur_len), 0);
        for (int i = 0; i < 50; i++) step(0, i % 2);
        chk("ovf_len50", 32'(cur_len), 50);
        chk("ovf_no_err", 32'(err_pulse), 0);
        step(0, 0);
        chk("ovf_err", 32'(err_pulse), 1);
        chk("ovf_len_clr", 32'(cur_len), 0);
        tick();
        chk("ovf_err_one_cycle", 32'(err_pulse), 0);

        // Fifth path: single goal step, k=4 -> done in cycle 6, then FULL
        step(9, 9);
        tick(); tick(); tick(); tick();
        chk("e_c5_done", 32'(done_pulse), 0);
        tick();
        chk("e_done", 32'(done_pulse), 1);
        chk("e_cnt", 32'(path_cnt), 5);
        chk("e_full", 32'(full), 1);
        chk("e_ready", 32'(step_ready), 0);
        chk("e_best_len", 32'(best_len), 1);
        chk("e_best_idx", 32'(best_idx), 4);

        // Steps are ignored while full
        step(0, 0);
        chk("full_len", 32'(cur_len), 0);
        chk("full_err", 32'(err_pulse), 0);
        chk("full_sticky", 32'(full), 1);
        rd(4, 0);
        chk("rd_4_0", 32'(rd_data), 32'h99);

        // Reset from FULL
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk_reset("rst_full");
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(step_ready), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
